irq_ctrl: RTL and testbench

//  Interrupt controller sitting between the board sources and the CPU core's interrupts input.
//  - Latches up to N_SRC interrupt sources into a pending register, applies a mask and a per-source

---
 rtl/irq_ctrl_pkg.sv | 16 +
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: FSM state codes and config register addresses shared by the
// interrupt controller top level and its testbench.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins.
// Purely combinational; o_valid is low when no bit is set (o_id then 0).
module irq_prio_enc #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_SRC-1:0] i_elig,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id
);

  // Scan upward and keep the first set bit found
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (i_elig[i] && !o_valid) begin
        o_valid = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller. Pending/mask/edge-select registers, fixed
// priority selection and the request/ack/eoi handshake towards the core.
// Optional feature macro IRQ_SYNC_EN: when defined, irq_src passes through a
// 2-flop synchroniser before edge/level logic (adds 2 cycles of latency).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id
);

  irq_state_t       r_state;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_edge;
  logic [N_SRC-1:0] r_src_q;
  logic             r_irq_o;
  logic [ID_W-1:0]  r_irq_id;

  logic [N_SRC-1:0] w_src;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_elig;
  logic             w_valid;
  logic [ID_W-1:0]  w_win;
  logic             w_ack_clr;
  logic             w_w1c;
  logic             w_withdraw;
  logic [7:0]       w_status;
  logic             w_unused_wdata;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;

  // Two-flop synchroniser for asynchronous board sources
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  assign w_rise    = w_src & ~r_src_q;
  assign w_elig    = r_pend & r_mask;
  assign w_ack_clr = (r_state == ST_ASSERT) && cpu_ack;
  assign w_w1c     = cfg_we && (cfg_addr == REG_PEND);
  assign w_withdraw = !r_mask[r_irq_id] || !r_pend[r_irq_id];
  assign w_status  = 8'({r_state, r_irq_id});
  assign w_unused_wdata = ^cfg_wdata;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .i_elig  (w_elig),
    .o_valid (w_valid),
    .o_id    (w_win)
  );

  // Next pending value: level bits track the source, edge bits set on a
  // rising edge and clear on ack or W1C, with set taking precedence
  always_comb begin
    w_pend_nxt = r_pend;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!r_edge[i]) begin
        w_pend_nxt[i] = w_src[i];
      end else if (w_rise[i]) begin
        w_pend_nxt[i] = 1'b1;
      end else if ((w_w1c && cfg_wdata[i]) ||
                   (w_ack_clr && (r_irq_id == ID_W'(i)))) begin
        w_pend_nxt[i] = 1'b0;
      end
    end
  end

  // Source history and pending register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src_q <= '0;
      r_pend  <= '0;
    end else begin
      r_src_q <= w_src;
      r_pend  <= w_pend_nxt;
    end
  end

  // Mask and edge-select config writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '0;
      r_edge <= '1;
    end else if (cfg_we) begin
      if (cfg_addr == REG_MASK) r_mask <= cfg_wdata[N_SRC-1:0];
      if (cfg_addr == REG_EDGE) r_edge <= cfg_wdata[N_SRC-1:0];
    end
  end

  // Request/ack/eoi handshake; ack is checked before withdrawal so a
  // simultaneous ack and mask-off still completes the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_irq_o  <= 1'b0;
      r_irq_id <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state  <= ST_ASSERT;
            r_irq_o  <= 1'b1;
            r_irq_id <= w_win;
          end
        end
        ST_ASSERT: begin
          if (cpu_ack) begin
            r_state <= ST_SERVICE;
            r_irq_o <= 1'b0;
          end else if (w_withdraw) begin
            r_state <= ST_IDLE;
            r_irq_o <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (cpu_eoi) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq_o <= 1'b0;
        end
      endcase
    end
  end

  // Combinational config read-back; unused bits read zero
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_MASK: cfg_rdata = 8'(r_mask);
      REG_PEND: cfg_rdata = 8'(r_pend);
      REG_EDGE: cfg_rdata = 8'(r_edge);
      REG_STAT: cfg_rdata = w_status;
      default:  cfg_rdata = '0;
    endcase
  end

  assign irq_o  = r_irq_o;
  assign irq_id = r_irq_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl. Stimulus pushes the
// expected {id, rise cycle} of each request; a negedge monitor pops and
// compares on every rising edge of irq_o. Register state is checked inline.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq_src = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic       cpu_ack = 1'b0;
  logic       cpu_eoi = 1'b0;
  logic       irq_o;
  logic [1:0] irq_id;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int id; int cyc; } exp_t;
  exp_t exp_q[$];

  irq_ctrl #(.N_SRC(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi),
    .irq_o(irq_o), .irq_id(irq_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new request must match the head of the scoreboard
  logic prev_irq = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_irq = 1'b0;
    end else begin
      if (irq_o && !prev_irq) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_request", 32'(irq_id), 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("request_id", 32'(irq_id), 32'(e.id));
          chk("request_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_irq = irq_o;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(string name, logic [1:0] a, logic [7:0] exp);
    cfg_addr = a;
    #1;
    chk(name, 32'(cfg_rdata), 32'(exp));
  endtask

  task automatic push(int id, int c);
    exp_t e;
    e.id = id; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_irq(string name);
    int n = 0;
    while (!irq_o && n < 20) begin tick(); n++; end
    if (!irq_o) chk(name, 32'(irq_o), 32'd1);
  endtask

  task automatic pulse(logic [3:0] s);
    irq_src = s;
    tick();
    irq_src = '0;
  endtask

  task automatic ack();
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
  endtask

  task automatic eoi();
    cpu_eoi = 1'b1; tick(); cpu_eoi = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_irq_o", 32'(irq_o), 32'd0);
    chk("rst_irq_id", 32'(irq_id), 32'd0);
    rd("rst_mask", REG_MASK, 8'h00);
    rd("rst_pend", REG_PEND, 8'h00);
    rd("rst_edge", REG_EDGE, 8'h0F);
    tick();
    rd("rst_stat", REG_STAT, 8'h00);
    rst = 1'b1;
    tick();

    // 1: single edge source, full handshake
    wr(REG_MASK, 8'h0F);
    push(2, cyc + LAT);
    pulse(4'b0100);
    wait_irq("t1_timeout");
    rd("t1_stat_assert", REG_STAT, 8'h06);
    ack();
    chk("t1_irq_after_ack", 32'(irq_o), 32'd0);
    rd("t1_pend_cleared", REG_PEND, 8'h00);
    rd("t1_stat_service", REG_STAT, 8'h0A);
    eoi();
    rd("t1_stat_idle", REG_STAT, 8'h02);

    // 2: two simultaneous sources, lower index first; ack+eoi together
    push(1, cyc + LAT);
    pulse(4'b1010);
    wait_irq("t2_timeout_a");
    cpu_ack = 1'b1; cpu_eoi = 1'b1;
    tick();
    cpu_ack = 1'b0; cpu_eoi = 1'b0;
    rd("t2_ack_only", REG_STAT, 8'h09);
    rd("t2_pend_3", REG_PEND, 8'h08);
    push(3, cyc + 2);
    eoi();
    wait_irq("t2_timeout_b");
    ack();
    eoi();
    rd("t2_pend_empty", REG_PEND, 8'h00);

    // 3: masked source stays pending, unmask raises request
    wr(REG_MASK, 8'h00);
    pulse(4'b0001);
    tick(LAT + 1);
    chk("t3_masked_irq", 32'(irq_o), 32'd0);
    rd("t3_pend", REG_PEND, 8'h01);
    push(0, cyc + 2);
    wr(REG_MASK, 8'h01);
    wait_irq("t3_timeout");

    // 4: mask write during ASSERT withdraws the request
    wr(REG_MASK, 8'h00);
    tick();
    chk("t4_withdrawn", 32'(irq_o), 32'd0);
    rd("t4_stat_idle", REG_STAT, 8'h00);
    rd("t4_pend_kept", REG_PEND, 8'h01);
    tick(3);
    wr(REG_PEND, 8'h01);
    rd("t4_w1c", REG_PEND, 8'h00);

    // 5: level source 3
    wr(REG_EDGE, 8'h07);
    wr(REG_MASK, 8'h08);
    push(3, cyc + LAT);
    irq_src = 4'b1000;
    tick();
    wait_irq("t5_timeout_a");
    ack();
    rd("t5_level_after_ack", REG_PEND, 8'h08);
    push(3, cyc + 2);
    eoi();
    wait_irq("t5_timeout_b");
    wr(REG_PEND, 8'h08);
    rd("t5_w1c_ignored", REG_PEND, 8'h08);
    chk("t5_still_req", 32'(irq_o), 32'd1);
    irq_src = '0;
    tick(LAT - 1);
    rd("t5_level_drop", REG_PEND, 8'h00);
    tick();
    chk("t5_withdraw", 32'(irq_o), 32'd0);
    rd("t5_stat", REG_STAT, 8'h03);

    // 6: reset during SERVICE, stray eoi afterwards
    wr(REG_EDGE, 8'h0F);
    wr(REG_MASK, 8'h0F);
    push(1, cyc + LAT);
    pulse(4'b0010);
    wait_irq("t6_timeout");
    ack();
    rd("t6_stat_service", REG_STAT, 8'h09);
    pulse(4'b0100);
    tick(LAT - 1);
    rd("t6_pend_accum", REG_PEND, 8'h04);
    rst = 1'b0;
    #1;
    chk("t6_rst_irq", 32'(irq_o), 32'd0);
    rd("t6_rst_mask", REG_MASK, 8'h00);
    rd("t6_rst_pend", REG_PEND, 8'h00);
    rd("t6_rst_stat", REG_STAT, 8'h00);
    tick(2);
    rst = 1'b1;
    tick();
    eoi();
    rd("t6_stray_eoi", REG_STAT, 8'h00);
    tick(3);
    chk("t6_no_irq", 32'(irq_o), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
